// File: rtl/serial_rx_ctrl.sv
// Frame controller for a serial-in shift register: finds the start bit, gates WIDTH shifts,
// checks even parity and the stop bit, and hands the word out through a one-entry valid/ready buffer.
module serial_rx_ctrl #(
    parameter int WIDTH     = 4,
    parameter bit PARITY_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sin,
    output logic             sh_en,
    output logic             sh_clr,
    input  logic [WIDTH-1:0] sh_q,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             busy,
    output logic             frame_err,
    output logic             parity_err,
    output logic             overrun,
    output logic [7:0]       err_cnt
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        PARITY,
        STOP,
        BREAK
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    bitcnt_q, bitcnt_d;
    logic             par_q, par_d;
    logic             par_ok_q, par_ok_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             frame_err_q, frame_err_d;
    logic             parity_err_q, parity_err_d;
    logic             overrun_q, overrun_d;
    logic [7:0]       err_cnt_q, err_cnt_d;

    always_comb begin
        state_d      = state_q;
        bitcnt_d     = bitcnt_q;
        par_d        = par_q;
        par_ok_d     = par_ok_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        frame_err_d  = 1'b0;
        parity_err_d = 1'b0;
        overrun_d    = 1'b0;
        err_cnt_d    = err_cnt_q;
        sh_en        = 1'b0;
        sh_clr       = 1'b0;

        // The consumer handshake is evaluated first so a delivery in the same cycle can refill the slot.
        if (dout_valid_q && dout_ready) begin
            dout_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                sh_clr = !sin;
                if (!sin) begin
                    state_d  = SHIFT;
                    bitcnt_d = '0;
                    par_d    = 1'b0;
                    par_ok_d = 1'b1;
                end
            end
            SHIFT: begin
                sh_en    = 1'b1;
                par_d    = par_q ^ sin;
                bitcnt_d = bitcnt_q + 1'b1;
                if (bitcnt_q == CW'(WIDTH - 1)) begin
                    bitcnt_d = '0;
                    state_d  = PARITY_EN ? PARITY : STOP;
                end
            end
            PARITY: begin
                par_ok_d = ((par_q ^ sin) == 1'b0);
                state_d  = STOP;
            end
            STOP: begin
                if (sin) begin
                    state_d = IDLE;
                    if (!par_ok_q) begin
                        parity_err_d = 1'b1;
                    end else if (!dout_valid_q || dout_ready) begin
                        dout_d       = sh_q;
                        dout_valid_d = 1'b1;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end else begin
                    state_d     = BREAK;
                    frame_err_d = 1'b1;
                end
            end
            BREAK: begin
                if (sin) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if ((frame_err_d || parity_err_d || overrun_d) && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            bitcnt_q     <= '0;
            par_q        <= 1'b0;
            par_ok_q     <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
            err_cnt_q    <= 8'd0;
        end else begin
            state_q      <= state_d;
            bitcnt_q     <= bitcnt_d;
            par_q        <= par_d;
            par_ok_q     <= par_ok_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overrun_q    <= overrun_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign busy       = (state_q != IDLE);
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign overrun    = overrun_q;
    assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_serial_rx_ctrl.sv
// Scoreboard bench for serial_rx_ctrl: frame-level reference model feeds an expected-event queue,
// an independent monitor pops and compares every pulse and every consumed word.
module tb_serial_rx_ctrl;

    localparam int WIDTH     = 4;
    localparam bit PARITY_EN = 1'b1;

    localparam int EV_WORD = 0;
    localparam int EV_PAR  = 1;
    localparam int EV_FRM  = 2;
    localparam int EV_OVR  = 3;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             sin = 1'b1;
    logic             dout_ready = 1'b0;
    logic             sh_en, sh_clr;
    logic [WIDTH-1:0] sh_q;
    logic [WIDTH-1:0] dout;
    logic             dout_valid, busy, frame_err, parity_err, overrun;
    logic [7:0]       err_cnt;

    serial_rx_ctrl #(.WIDTH(WIDTH), .PARITY_EN(PARITY_EN)) dut (
        .clk(clk), .reset(reset), .sin(sin),
        .sh_en(sh_en), .sh_clr(sh_clr), .sh_q(sh_q),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .busy(busy), .frame_err(frame_err), .parity_err(parity_err),
        .overrun(overrun), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    // Stand-in for the external shift register the controller drives.
    logic [WIDTH-1:0] shreg = '0;
    always @(posedge clk) begin
        if (reset || sh_clr) shreg <= '0;
        else if (sh_en)      shreg <= {shreg[WIDTH-2:0], sin};
    end
    assign sh_q = shreg;

    typedef struct {
        int               kind;
        logic [WIDTH-1:0] data;
    } evt_t;

    evt_t             exp_q[$];
    int               n_checks = 0;
    int               n_pass = 0;
    logic             buf_v = 1'b0;
    logic [WIDTH-1:0] buf_d = '0;
    int               exp_err = 0;
    logic [31:0]      sh_en_hist = '0;
    logic [31:0]      valid_hist = '0;
    logic [31:0]      busy_hist = '0;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic void push_evt(input int kind, input logic [WIDTH-1:0] data);
        evt_t e;
        e.kind = kind;
        e.data = data;
        exp_q.push_back(e);
        if (kind != EV_WORD && exp_err < 255) exp_err++;
    endfunction

    task automatic match_evt(input int kind, input logic [WIDTH-1:0] data);
        evt_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            $display("[TB] FAIL unexpected event: got kind %0d data %0h, expected none", kind, data);
        end else begin
            e = exp_q.pop_front();
            check_output("event kind", kind, e.kind);
            if (kind == EV_WORD) check_output("dout word", data, e.data);
        end
    endtask

    // Monitor: every observable output event is checked against the model's queue.
    always @(negedge clk) begin
        if (!reset) begin
            if (parity_err) match_evt(EV_PAR, '0);
            if (frame_err)  match_evt(EV_FRM, '0);
            if (overrun)    match_evt(EV_OVR, '0);
            if (dout_valid && dout_ready) match_evt(EV_WORD, dout);
        end
    end

    // One clock cycle of stimulus; evt >= 0 marks the stop-bit cycle with the frame's outcome.
    task automatic tick(input logic s, input logic r, input int evt, input logic [WIDTH-1:0] d,
                        input logic rst);
        @(posedge clk);
        #1;
        sin        = s;
        dout_ready = r;
        reset      = rst;
        if (rst) begin
            buf_v   = 1'b0;
            exp_err = 0;
            exp_q.delete();
        end else begin
            if (buf_v && r) begin
                push_evt(EV_WORD, buf_d);
                buf_v = 1'b0;
            end
            if (evt == EV_WORD) begin
                if (buf_v) push_evt(EV_OVR, d);
                else begin
                    buf_v = 1'b1;
                    buf_d = d;
                end
            end else if (evt > 0) begin
                push_evt(evt, d);
            end
        end
        @(negedge clk);
        sh_en_hist = {sh_en_hist[30:0], sh_en};
        valid_hist = {valid_hist[30:0], dout_valid};
        busy_hist  = {busy_hist[30:0], busy};
    endtask

    // mode: 0 never ready, 1 always ready, 2 random, 3 ready only on the stop cycle
    function automatic logic rdy(input int mode, input bit stop_cycle);
        case (mode)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return 1'($urandom_range(0, 1));
            default: return stop_cycle;
        endcase
    endfunction

    task automatic send_frame(input logic [WIDTH-1:0] d, input logic p, input logic s,
                              input int mode, input int brk);
        int kind;
        if (!s)                          kind = EV_FRM;
        else if (PARITY_EN && ((^d) ^ p)) kind = EV_PAR;
        else                             kind = EV_WORD;
        tick(1'b0, rdy(mode, 0), -1, d, 1'b0);
        for (int i = WIDTH - 1; i >= 0; i--) tick(d[i], rdy(mode, 0), -1, d, 1'b0);
        if (PARITY_EN) tick(p, rdy(mode, 0), -1, d, 1'b0);
        tick(s, rdy(mode, 1), kind, d, 1'b0);
        if (!s) begin
            repeat (brk) tick(1'b0, rdy(mode, 0), -1, d, 1'b0);
            tick(1'b1, rdy(mode, 0), -1, d, 1'b0);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [WIDTH-1:0] d;
        logic             p, s;

        tick(1'b1, 1'b0, -1, '0, 1'b1);
        tick(1'b1, 1'b0, -1, '0, 1'b1);
        tick(1'b1, 1'b0, -1, '0, 1'b0);
        check_output("reset dout", dout, 0);
        check_output("reset dout_valid", dout_valid, 0);
        check_output("reset busy", busy, 0);
        check_output("reset err_cnt", err_cnt, 0);
        check_output("reset pulses", {frame_err, parity_err, overrun}, 0);

        // Good frame 4'hB, consumer stalled.
        send_frame(4'hB, 1'b1, 1'b1, 0, 0);
        tick(1'b1, 1'b0, -1, '0, 1'b0);
        check_output("sh_en window", sh_en_hist[7:0], 8'b0111_1000);
        check_output("dout_valid latency", valid_hist[7:0], 8'b0000_0001);
        check_output("dout after frame", dout, 4'hB);
        tick(1'b1, 1'b1, -1, '0, 1'b0);

        // Bad parity: word discarded.
        send_frame(4'hB, 1'b0, 1'b1, 0, 0);
        tick(1'b1, 1'b0, -1, '0, 1'b0);
        check_output("parity frame dout_valid", dout_valid, 0);
        check_output("err_cnt after parity", err_cnt, 8'(exp_err));

        // Stop bit 0, line held low: BREAK must not accept a start.
        send_frame(4'h5, 1'b0, 1'b0, 0, 3);
        tick(1'b1, 1'b0, -1, '0, 1'b0);
        check_output("break busy", busy_hist[4:0], 5'b11110);
        check_output("break sh_en", sh_en_hist[4:0], 5'b00000);
        check_output("err_cnt after break", err_cnt, 8'(exp_err));

        // Back-to-back frames into a full buffer, then with a same-cycle handshake.
        send_frame(4'hB, 1'b1, 1'b1, 0, 0);
        send_frame(4'h6, 1'b0, 1'b1, 0, 0);
        tick(1'b1, 1'b0, -1, '0, 1'b0);
        check_output("overrun keeps old word", dout, 4'hB);
        check_output("overrun keeps valid", dout_valid, 1);
        tick(1'b1, 1'b1, -1, '0, 1'b0);
        send_frame(4'hB, 1'b1, 1'b1, 0, 0);
        send_frame(4'h6, 1'b0, 1'b1, 3, 0);
        tick(1'b1, 1'b0, -1, '0, 1'b0);
        check_output("refill dout", dout, 4'h6);
        check_output("refill valid", dout_valid, 1);
        check_output("err_cnt after overrun", err_cnt, 8'(exp_err));

        // Reset in cycle 3 of a frame.
        tick(1'b0, 1'b0, -1, '0, 1'b0);
        tick(1'b1, 1'b0, -1, '0, 1'b0);
        tick(1'b0, 1'b0, -1, '0, 1'b0);
        tick(1'b1, 1'b0, -1, '0, 1'b1);
        tick(1'b1, 1'b0, -1, '0, 1'b0);
        check_output("mid-frame reset busy", busy, 0);
        check_output("mid-frame reset valid", dout_valid, 0);
        check_output("mid-frame reset dout", dout, 0);
        check_output("mid-frame reset err_cnt", err_cnt, 0);
        send_frame(4'h9, 1'b0, 1'b1, 0, 0);
        tick(1'b1, 1'b1, -1, '0, 1'b0);
        tick(1'b1, 1'b0, -1, '0, 1'b0);

        // Randomized frames with random consumer readiness.
        for (int n = 0; n < 60; n++) begin
            d = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
            p = (^d) ^ ($urandom_range(0, 5) == 0);
            s = ($urandom_range(0, 7) != 0);
            send_frame(d, p, s, 2, int'($urandom_range(0, 3)));
            repeat ($urandom_range(0, 2)) tick(1'b1, 1'($urandom_range(0, 1)), -1, '0, 1'b0);
        end
        repeat (3) tick(1'b1, 1'b1, -1, '0, 1'b0);
        check_output("random err_cnt", err_cnt, 8'(exp_err));
        check_output("random valid drained", dout_valid, 0);

        // Saturation of the error counter.
        for (int n = 0; n < 300; n++) begin
            send_frame(4'hA, 1'b0, 1'b0, 0, 0);
        end
        tick(1'b1, 1'b0, -1, '0, 1'b0);
        check_output("err_cnt saturated", err_cnt, 8'hFF);

        tick(1'b1, 1'b0, -1, '0, 1'b0);
        check_output("pending events", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
